ysyx_25040109_regfile_csr_v2: RTL and testbench

Next-generation architectural state block for the ysyx_25040109 core. It holds a parametrised GPR file with two read ports, one write port and same-cycle write-to-read bypass. A per-register pending scoreboard lets the front end detect RAW hazards. A machine-mode CSR unit provides RW/RS/RC operations, atomic trap entry/mret sequencing and a free-running 64-bit mcycle counter.

---
 rtl/ysyx_25040109_regfile_csr_v2.sv | 204 ++++++++++++++++++++
 tb/tb_ysyx_25040109_regfile_csr_v2.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040109_regfile_csr_v2.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25040109_regfile_csr_v2
//  Purpose  : GPR file (2R/1W, write-to-read bypass), RAW pending scoreboard,
//             machine-mode CSR unit (RW/RS/RC, trap entry, mret, mcycle).
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_25040109_regfile_csr_v2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NREG       = 32,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  busy1,
  output logic                  busy2,
  output logic [DATA_WIDTH-1:0] a0_out,
  input  logic                  csr_valid,
  input  logic [1:0]            csr_op,
  input  logic [11:0]           csr_addr,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  csr_illegal,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic                  mret_valid,
  output logic [DATA_WIDTH-1:0] mtvec_out,
  output logic [DATA_WIDTH-1:0] mepc_out,
  output logic                  mie_out
);

  localparam logic [11:0] C_MSTATUS  = 12'h300;
  localparam logic [11:0] C_MTVEC    = 12'h305;
  localparam logic [11:0] C_MSCRATCH = 12'h340;
  localparam logic [11:0] C_MEPC     = 12'h341;
  localparam logic [11:0] C_MCAUSE   = 12'h342;
  localparam logic [11:0] C_MCYCLE   = 12'hB00;
  localparam logic [11:0] C_MCYCLEH  = 12'hB80;
  localparam logic [DATA_WIDTH-1:0] C_ALIGN_MASK = ~DATA_WIDTH'(3);

  // x0 is hard-wired, so storage starts at index 1
  logic [DATA_WIDTH-1:0]   gpr_q [1:NREG-1];
  logic [NREG-1:1]         pend_q, pend_d;
  logic                    mie_q, mie_d, mpie_q, mpie_d;
  logic [DATA_WIDTH-1:0]   mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [DATA_WIDTH-1:0]   mcause_q, mcause_d, mscratch_q, mscratch_d;
  logic [2*DATA_WIDTH-1:0] mcycle_q, mcycle_d;
  logic                    csr_mapped, csr_wr;
  logic [DATA_WIDTH-1:0]   csr_old, csr_new, mstatus_rd;

  // Read ports: unimplemented indices fall through to 0; bypass the write port
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    busy1  = 1'b0;
    busy2  = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (raddr1 == ADDR_WIDTH'(i)) begin
        rdata1 = (BYPASS != 0 && wen && waddr == ADDR_WIDTH'(i)) ? wdata : gpr_q[i];
        busy1  = pend_q[i];
      end
      if (raddr2 == ADDR_WIDTH'(i)) begin
        rdata2 = (BYPASS != 0 && wen && waddr == ADDR_WIDTH'(i)) ? wdata : gpr_q[i];
        busy2  = pend_q[i];
      end
    end
  end

  // GPR storage: writes to x0 or out-of-range indices match no entry
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 1; i < NREG; i++) gpr_q[i] <= '0;
    end else if (wen) begin
      for (int i = 1; i < NREG; i++)
        if (waddr == ADDR_WIDTH'(i)) gpr_q[i] <= wdata;
    end
  end

  // Scoreboard next state: clear on writeback, then set on issue so set wins
  always_comb begin
    pend_d = pend_q;
    for (int i = 1; i < NREG; i++) begin
      if (wen && waddr == ADDR_WIDTH'(i))      pend_d[i] = 1'b0;
      if (iss_valid && iss_rd == ADDR_WIDTH'(i)) pend_d[i] = 1'b1;
    end
  end

  // Scoreboard register
  always_ff @(posedge clock) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  generate
    if (NREG > 10) begin : g_a0
      assign a0_out = gpr_q[10];
    end else begin : g_no_a0
      assign a0_out = '0;
    end
  endgenerate

  // CSR read mux; unmapped addresses read 0 and flag illegal
  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[3]     = mie_q;
    csr_mapped        = 1'b1;
    csr_old           = '0;
    case (csr_addr)
      C_MSTATUS:  csr_old = mstatus_rd;
      C_MTVEC:    csr_old = mtvec_q;
      C_MSCRATCH: csr_old = mscratch_q;
      C_MEPC:     csr_old = mepc_q;
      C_MCAUSE:   csr_old = mcause_q;
      C_MCYCLE:   csr_old = mcycle_q[DATA_WIDTH-1:0];
      C_MCYCLEH:  csr_old = mcycle_q[2*DATA_WIDTH-1:DATA_WIDTH];
      default:    csr_mapped = 1'b0;
    endcase
    case (csr_op)
      2'b01:   csr_new = csr_wdata;
      2'b10:   csr_new = csr_old | csr_wdata;
      2'b11:   csr_new = csr_old & ~csr_wdata;
      default: csr_new = csr_old;
    endcase
    // Set/clear with a zero operand is a pure read; trap and mret pre-empt writes
    csr_wr = csr_valid && csr_mapped && !trap_valid && !mret_valid &&
             (csr_op == 2'b01 || (csr_op[1] && csr_wdata != '0));
  end

  assign csr_rdata   = csr_old;
  assign csr_illegal = csr_valid && !csr_mapped;
  assign mtvec_out   = mtvec_q;
  assign mepc_out    = mepc_q;
  assign mie_out     = mie_q;

  // CSR next state with priority trap > mret > CSR write; mcycle counts unless written
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mscratch_d = mscratch_q;
    mcycle_d   = mcycle_q + 1'b1;
    if (trap_valid) begin
      mepc_d   = trap_pc & C_ALIGN_MASK;
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_valid) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_wr) begin
      case (csr_addr)
        C_MSTATUS: begin
          mie_d  = csr_new[3];
          mpie_d = csr_new[7];
        end
        C_MTVEC:    mtvec_d    = csr_new & C_ALIGN_MASK;
        C_MSCRATCH: mscratch_d = csr_new;
        C_MEPC:     mepc_d     = csr_new & C_ALIGN_MASK;
        C_MCAUSE:   mcause_d   = csr_new;
        C_MCYCLE:   mcycle_d   = {mcycle_q[2*DATA_WIDTH-1:DATA_WIDTH], csr_new};
        C_MCYCLEH:  mcycle_d   = {csr_new, mcycle_q[DATA_WIDTH-1:0]};
        default:    mcycle_d   = mcycle_q + 1'b1;
      endcase
    end
  end

  // CSR state registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
      mcycle_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mscratch_q <= mscratch_d;
      mcycle_q   <= mcycle_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040109_regfile_csr_v2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_25040109_regfile_csr_v2
//  Purpose  : Scoreboard bench: driver pushes model-predicted outputs, a
//             monitor pops and compares once per cycle before the clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_25040109_regfile_csr_v2;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  raddr1, raddr2, waddr, iss_rd;
  logic [31:0] rdata1, rdata2, wdata, a0_out;
  logic        wen, iss_valid, busy1, busy2;
  logic        csr_valid, csr_illegal, trap_valid, mret_valid, mie_out;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, trap_pc, trap_cause, mtvec_out, mepc_out;

  ysyx_25040109_regfile_csr_v2 dut (
    .clock(clock), .reset(reset),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy1(busy1), .busy2(busy2),
    .a0_out(a0_out),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_valid(mret_valid), .mtvec_out(mtvec_out), .mepc_out(mepc_out),
    .mie_out(mie_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] r1, r2, a0, csr, mtvec, mepc;
    logic        b1, b2, ill, mie;
    logic        d_csr_en, d_r1_en, d_b1_en, d_b1;
    logic [31:0] d_csr, d_r1;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Directed expectations attached to the next issued cycle
  logic        d_csr_en = 0, d_r1_en = 0, d_b1_en = 0, d_b1 = 0;
  logic [31:0] d_csr = 0, d_r1 = 0;

  // Reference architectural state
  logic [31:0] m_gpr [32];
  logic        m_pend [32];
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscratch;
  logic [63:0] m_mcycle;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
  endfunction

  function automatic logic [31:0] m_csr(input logic [11:0] a, output logic mapped);
    mapped = 1'b1;
    case (a)
      12'h300: return 32'h1800 | (m_mie ? 32'h8 : 0) | (m_mpie ? 32'h80 : 0);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_mcycle[31:0];
      12'hB80: return m_mcycle[63:32];
      default: begin mapped = 1'b0; return 32'h0; end
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wen && waddr == a) return wdata;
    return m_gpr[a];
  endfunction

  function automatic exp_t m_expect();
    exp_t e;
    logic mp;
    e.r1 = m_read(raddr1);
    e.r2 = m_read(raddr2);
    e.b1 = m_pend[raddr1];
    e.b2 = m_pend[raddr2];
    e.a0 = m_gpr[10];
    e.csr = m_csr(csr_addr, mp);
    e.ill = csr_valid && !mp;
    e.mtvec = m_mtvec;
    e.mepc = m_mepc;
    e.mie = m_mie;
    e.d_csr_en = d_csr_en; e.d_csr = d_csr;
    e.d_r1_en = d_r1_en;   e.d_r1 = d_r1;
    e.d_b1_en = d_b1_en;   e.d_b1 = d_b1;
    return e;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin m_gpr[i] = 0; m_pend[i] = 0; end
    m_mie = 0; m_mpie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
    m_mcycle = 0;
  endtask

  // Architectural effect of one clock edge with the inputs currently applied
  task automatic m_edge();
    logic        mp, wr, cyc_written;
    logic [31:0] old, nv;
    if (!reset) begin m_reset(); return; end
    if (wen && waddr != 0) m_gpr[waddr] = wdata;
    if (wen) m_pend[waddr] = 0;
    if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1;
    old = m_csr(csr_addr, mp);
    nv  = (csr_op == 2'b01) ? csr_wdata : (csr_op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
    wr  = csr_valid && mp && (csr_op == 2'b01 || (csr_op[1] && csr_wdata != 0));
    cyc_written = 0;
    if (trap_valid) begin
      m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mpie = m_mie; m_mie = 0;
    end else if (mret_valid) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (wr) begin
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec = nv & ~32'h3;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'hB00: begin m_mcycle[31:0] = nv; cyc_written = 1; end
        12'hB80: begin m_mcycle[63:32] = nv; cyc_written = 1; end
        default: ;
      endcase
    end
    if (!cyc_written) m_mcycle = m_mcycle + 64'd1;
  endtask

  task automatic idle();
    wen = 0; iss_valid = 0; csr_valid = 0; csr_op = 0; trap_valid = 0; mret_valid = 0;
  endtask

  // Called at a falling edge with inputs already applied
  task automatic step();
    exp_t e;
    #1;
    e = m_expect();
    q.push_back(e);
    d_csr_en = 0; d_r1_en = 0; d_b1_en = 0;
    @(posedge clock);
    m_edge();
    @(negedge clock);
    idle();
  endtask

  task automatic csr_acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] v);
    csr_valid = 1; csr_op = op; csr_addr = a; csr_wdata = v;
    step();
  endtask

  task automatic rd_csr(input logic [11:0] a, input logic [31:0] v);
    csr_valid = 1; csr_op = 2'b00; csr_addr = a; csr_wdata = 0;
    d_csr_en = 1; d_csr = v;
    step();
  endtask

  // Monitor: compare the oldest prediction just before the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #4;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rdata1", rdata1, e.r1);
        chk("rdata2", rdata2, e.r2);
        chk("busy1", 32'(busy1), 32'(e.b1));
        chk("busy2", 32'(busy2), 32'(e.b2));
        chk("a0_out", a0_out, e.a0);
        chk("csr_rdata", csr_rdata, e.csr);
        chk("csr_illegal", 32'(csr_illegal), 32'(e.ill));
        chk("mtvec_out", mtvec_out, e.mtvec);
        chk("mepc_out", mepc_out, e.mepc);
        chk("mie_out", 32'(mie_out), 32'(e.mie));
        if (e.d_csr_en) chk("dir_csr", csr_rdata, e.d_csr);
        if (e.d_r1_en)  chk("dir_rdata1", rdata1, e.d_r1);
        if (e.d_b1_en)  chk("dir_busy1", 32'(busy1), 32'(e.d_b1));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [11:0] C_ADDRS [10] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340,
                                           12'hB00, 12'hB80, 12'h7C0, 12'h301, 12'hF14};

  initial begin
    m_reset();
    reset = 0; raddr1 = 0; raddr2 = 0; waddr = 0; wdata = 0; iss_rd = 0;
    csr_addr = 0; csr_wdata = 0; trap_pc = 0; trap_cause = 0;
    idle();
    @(negedge clock);
    // Reset must override simultaneous activity
    wen = 1; waddr = 3; wdata = 32'h55; iss_valid = 1; iss_rd = 4; trap_valid = 1;
    trap_pc = 32'h100; trap_cause = 32'h7; csr_valid = 1; csr_op = 1; csr_addr = 12'h340;
    csr_wdata = 32'hAAAA;
    step();
    step();
    reset = 1;
    rd_csr(12'hB00, 0);
    rd_csr(12'hB00, 1);
    rd_csr(12'h300, 32'h1800);
    rd_csr(12'h340, 0);

    // Bypass and x0
    wen = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr1 = 5; d_r1_en = 1; d_r1 = 32'hDEADBEEF; step();
    raddr1 = 5; d_r1_en = 1; d_r1 = 32'hDEADBEEF; step();
    wen = 1; waddr = 0; wdata = 1; raddr1 = 0; d_r1_en = 1; d_r1 = 0; step();
    raddr1 = 0; d_r1_en = 1; d_r1 = 0; step();

    // Scoreboard
    raddr1 = 7; iss_valid = 1; iss_rd = 7; d_b1_en = 1; d_b1 = 0; step();
    wen = 1; waddr = 7; wdata = 32'h7; iss_valid = 1; iss_rd = 7; d_b1_en = 1; d_b1 = 1; step();
    wen = 1; waddr = 7; wdata = 32'h77; d_b1_en = 1; d_b1 = 1; step();
    d_b1_en = 1; d_b1 = 0; step();

    // CSR operations
    csr_acc(2'b01, 12'h305, 32'h80000003);
    rd_csr(12'h305, 32'h80000000);
    csr_acc(2'b10, 12'h300, 32'h8);
    rd_csr(12'h300, 32'h1808);
    csr_acc(2'b11, 12'h300, 32'h0);
    rd_csr(12'h300, 32'h1808);
    d_csr_en = 1; d_csr = 0; csr_acc(2'b01, 12'h7C0, 32'hFFFF);

    // Trap entry and mret
    trap_valid = 1; trap_pc = 32'h80000104; trap_cause = 32'hB; step();
    rd_csr(12'h341, 32'h80000104);
    rd_csr(12'h342, 32'hB);
    rd_csr(12'h300, 32'h1880);
    mret_valid = 1; step();
    rd_csr(12'h300, 32'h1888);
    trap_valid = 1; trap_pc = 32'h80000202; trap_cause = 32'h5;
    csr_acc(2'b01, 12'h341, 32'h1234);
    rd_csr(12'h341, 32'h80000200);
    rd_csr(12'h300, 32'h1880);

    // mcycle carry and 64-bit wrap
    csr_acc(2'b01, 12'hB00, 32'hFFFFFFFF);
    csr_acc(2'b01, 12'hB80, 32'h0);
    rd_csr(12'hB00, 32'hFFFFFFFF);
    rd_csr(12'hB00, 32'h0);
    rd_csr(12'hB80, 32'h1);
    csr_acc(2'b01, 12'hB00, 32'hFFFFFFFF);
    csr_acc(2'b01, 12'hB80, 32'hFFFFFFFF);
    rd_csr(12'hB00, 32'hFFFFFFFF);
    rd_csr(12'hB80, 32'h0);
    rd_csr(12'hB00, 32'h1);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) != 0);
      raddr1 = 5'($urandom); raddr2 = 5'($urandom);
      wen = ($urandom_range(0, 1) == 1); waddr = 5'($urandom); wdata = $urandom;
      iss_valid = ($urandom_range(0, 2) == 0); iss_rd = 5'($urandom);
      csr_valid = ($urandom_range(0, 4) < 2); csr_op = 2'($urandom);
      csr_addr = C_ADDRS[$urandom_range(0, 9)];
      csr_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      trap_valid = ($urandom_range(0, 19) == 0); trap_pc = $urandom; trap_cause = $urandom;
      mret_valid = ($urandom_range(0, 19) == 0);
      step();
    end

    // Mid-run reset
    reset = 1;
    csr_acc(2'b01, 12'h305, 32'h1000);
    wen = 1; waddr = 9; wdata = 32'h99; step();
    reset = 0; wen = 1; waddr = 5; wdata = 32'h1; iss_valid = 1; iss_rd = 6;
    mret_valid = 1; step();
    reset = 1;
    raddr1 = 9; raddr2 = 6; d_r1_en = 1; d_r1 = 0;
    rd_csr(12'hB00, 0);
    rd_csr(12'h300, 32'h1800);
    rd_csr(12'h305, 0);
    rd_csr(12'h341, 0);
    rd_csr(12'h342, 0);

    #6;
    chk("scoreboard_drain", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
